// File: rtl/raster_address_generator.sv
// Rectangular 2D address walker: emits base + row*stride + col for a
// (cols+1) x (rows+1) region under a ready/valid handshake, with optional frame repeat.
module raster_address_generator #(
    parameter int ADDR_W = 16,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              repeat_mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [COL_W-1:0]  cols,
    input  logic [ROW_W-1:0]  rows,
    input  logic [ADDR_W-1:0] stride,
    input  logic              ready,
    output logic [ADDR_W-1:0] address,
    output logic              nd,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              last_col,
    output logic              last,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state,    w_state_next;
    logic [ADDR_W-1:0] r_base,     w_base_next;
    logic [COL_W-1:0]  r_cols,     w_cols_next;
    logic [ROW_W-1:0]  r_rows,     w_rows_next;
    logic [ADDR_W-1:0] r_stride,   w_stride_next;
    logic              r_repeat,   w_repeat_next;
    logic [ADDR_W-1:0] r_address,  w_address_next;
    logic [ADDR_W-1:0] r_row_base, w_row_base_next;
    logic [COL_W-1:0]  r_col,      w_col_next;
    logic [ROW_W-1:0]  r_row,      w_row_next;
    logic              r_done,     w_done_next;

    logic w_run;
    logic w_last_col;
    logic w_last;
    logic [ADDR_W-1:0] w_next_row_base;

    // Flags come only from registered state, so ready/start never reach an output.
    assign w_run           = (r_state == S_RUN);
    assign w_last_col      = w_run && (r_col == r_cols);
    assign w_last          = w_last_col && (r_row == r_rows);
    assign w_next_row_base = r_row_base + r_stride;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_next    = r_state;
        w_base_next     = r_base;
        w_cols_next     = r_cols;
        w_rows_next     = r_rows;
        w_stride_next   = r_stride;
        w_repeat_next   = r_repeat;
        w_address_next  = r_address;
        w_row_base_next = r_row_base;
        w_col_next      = r_col;
        w_row_next      = r_row;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next    = S_RUN;
                    w_base_next     = base;
                    w_cols_next     = cols;
                    w_rows_next     = rows;
                    w_stride_next   = stride;
                    w_repeat_next   = repeat_mode;
                    w_address_next  = base;
                    w_row_base_next = base;
                    w_col_next      = '0;
                    w_row_next      = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (ready) begin
                    if (w_last) begin
                        w_done_next = 1'b1;
                        if (r_repeat) begin
                            w_address_next  = r_base;
                            w_row_base_next = r_base;
                            w_col_next      = '0;
                            w_row_next      = '0;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else if (w_last_col) begin
                        w_col_next      = '0;
                        w_row_next      = r_row + ROW_W'(1);
                        w_row_base_next = w_next_row_base;
                        w_address_next  = w_next_row_base;
                    end else begin
                        w_col_next     = r_col + COL_W'(1);
                        w_address_next = r_address + ADDR_W'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_cols     <= '0;
            r_rows     <= '0;
            r_stride   <= '0;
            r_repeat   <= 1'b0;
            r_address  <= '0;
            r_row_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_base     <= w_base_next;
            r_cols     <= w_cols_next;
            r_rows     <= w_rows_next;
            r_stride   <= w_stride_next;
            r_repeat   <= w_repeat_next;
            r_address  <= w_address_next;
            r_row_base <= w_row_base_next;
            r_col      <= w_col_next;
            r_row      <= w_row_next;
            r_done     <= w_done_next;
        end
    end

    assign address  = r_address;
    assign nd       = w_run;
    assign busy     = w_run;
    assign col      = r_col;
    assign row      = r_row;
    assign last_col = w_last_col;
    assign last     = w_last;
    assign done     = r_done;

endmodule

// File: tb/tb_raster_address_generator.sv
// Randomized bench for raster_address_generator; expected beats come from
// the closed-form address base + row*stride + col evaluated per transfer index.
module tb_raster_address_generator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        repeat_mode = 1'b0;
    logic [15:0] base = '0;
    logic [7:0]  cols = '0;
    logic [7:0]  rows = '0;
    logic [15:0] stride = '0;
    logic        ready = 1'b0;
    logic [15:0] address;
    logic        nd;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        last_col;
    logic        last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    raster_address_generator #(.ADDR_W(16), .COL_W(8), .ROW_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .repeat_mode(repeat_mode),
        .base(base), .cols(cols), .rows(rows), .stride(stride), .ready(ready),
        .address(address), .nd(nd), .col(col), .row(row), .last_col(last_col),
        .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Outputs are observed 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {address,col,row,nd,busy,done,last_col,last} for the idx-th beat of a scan.
    function automatic logic [36:0] model_beat(input logic [15:0] b, input logic [7:0] c,
                                               input logic [7:0] r, input logic [15:0] s,
                                               input int idx, input logic dn);
        int per, e, cc, rr;
        logic [15:0] a;
        logic lc, l;
        per = (int'(c) + 1) * (int'(r) + 1);
        e   = idx % per;
        cc  = e % (int'(c) + 1);
        rr  = e / (int'(c) + 1);
        a   = 16'(int'(b) + rr * int'(s) + cc);
        lc  = (cc == int'(c));
        l   = lc && (rr == int'(r));
        return {a, 8'(cc), 8'(rr), 1'b1, 1'b1, dn, lc, l};
    endfunction

    // One scan: start, n_frames frames (stop_at>=0 aborts with stop after that many transfers).
    task automatic run_scan(input string name, input logic [15:0] b, input logic [7:0] c,
                            input logic [7:0] r, input logic [15:0] s, input logic rep,
                            input int rmode, input int n_frames, input int stop_at,
                            input bit glitch);
        int n, idx, cyc, budget, per, e;
        logic exp_done;
        logic [36:0] obs, exp_v;
        logic [4:0] obs_f;
        per      = (int'(c) + 1) * (int'(r) + 1);
        n        = (stop_at >= 0) ? stop_at : per * n_frames;
        budget   = 4 * n + 20;
        idx      = 0;
        cyc      = 0;
        exp_done = 1'b0;

        base = b; cols = c; rows = r; stride = s; repeat_mode = rep;
        start = 1'b1;
        stop  = 1'b0;
        ready = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;

        while (idx < n && cyc < budget) begin
            // Latched parameters must not follow these while busy.
            base = 16'($urandom); cols = 8'($urandom); rows = 8'($urandom);
            stride = 16'($urandom); repeat_mode = 1'($urandom);
            start = glitch ? ($urandom_range(0, 4) == 0) : 1'b0;

            obs   = {address, col, row, nd, busy, done, last_col, last};
            exp_v = model_beat(b, c, r, s, idx, exp_done);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s beat %0d: got addr=%h col=%0d row=%0d nd/busy/done/lc/l=%b expected addr=%h col=%0d row=%0d nd/busy/done/lc/l=%b",
                         name, idx, obs[36:21], obs[20:13], obs[12:5], obs[4:0],
                         exp_v[36:21], exp_v[20:13], exp_v[12:5], exp_v[4:0]);
            end

            case (rmode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 3 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            exp_done = 1'b0;
            if (ready) begin
                e = idx % per;
                if (e == per - 1) exp_done = 1'b1;
                idx++;
            end
            cyc++;
            tick();
        end
        start = 1'b0;

        if (idx < n) begin
            total++;
            bad++;
            $display("FAIL %s timeout: %0d of %0d transfers within %0d cycles", name, idx, n, budget);
        end else if (stop_at >= 0) begin
            // Still running: after a frame wrap or mid-frame.
            obs   = {address, col, row, nd, busy, done, last_col, last};
            exp_v = model_beat(b, c, r, s, idx, exp_done);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s pre-stop: got %h expected %h", name, obs, exp_v);
            end
            stop  = 1'b1;
            ready = 1'($urandom_range(0, 1));
            tick();
            stop  = 1'b0;
            ready = 1'b0;
            obs_f = {nd, busy, done, last_col, last};
            total++;
            if (obs_f !== 5'b00000) begin
                bad++;
                $display("FAIL %s stop: nd/busy/done/lc/l got %b expected 00000", name, obs_f);
            end
        end else begin
            // Done cycle of a non-repeating frame.
            obs_f = {nd, busy, done, last_col, last};
            total++;
            if (obs_f !== 5'b00100) begin
                bad++;
                $display("FAIL %s done: nd/busy/done/lc/l got %b expected 00100", name, obs_f);
            end
        end
    endtask

    task automatic test_reset();
        logic [36:0] obs, exp_v;
        reset = 1'b1;
        tick();
        tick();
        obs = {address, col, row, nd, busy, done, last_col, last};
        total++;
        if (obs !== 37'd0) begin
            bad++;
            $display("FAIL reset_initial: got %h expected 0", obs);
        end
        reset = 1'b0;
        tick();

        // Reset mid-scan at row 1, col 2.
        base = 16'h0100; cols = 8'd3; rows = 8'd2; stride = 16'h0010; repeat_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        obs   = {address, col, row, nd, busy, done, last_col, last};
        exp_v = model_beat(16'h0100, 8'd3, 8'd2, 16'h0010, 6, 1'b0);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_prescan: got %h expected %h", obs, exp_v);
        end
        reset = 1'b1;
        tick();
        obs = {address, col, row, nd, busy, done, last_col, last};
        total++;
        if (obs !== 37'd0) begin
            bad++;
            $display("FAIL reset_midscan: got %h expected 0", obs);
        end
        reset = 1'b0;
        ready = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_scan("basic", 16'h0100, 8'd3, 8'd2, 16'h0010, 1'b0, 0, 1, -1, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        run_scan("backpressure", 16'h0100, 8'd3, 8'd2, 16'h0010, 1'b0, 1, 1, -1, 1'b1);
        tick();
    endtask

    task automatic test_repeat_stop();
        run_scan("repeat_wrap", 16'hFFFE, 8'd1, 8'd1, 16'h0002, 1'b1, 0, 3, 12, 1'b1);
        tick();
        run_scan("repeat_stall", 16'hFFFE, 8'd1, 8'd1, 16'h0002, 1'b1, 2, 2, 9, 1'b1);
        tick();
        run_scan("stop_midframe", 16'h1234, 8'd4, 8'd3, 16'h0100, 1'b0, 2, 1, 7, 1'b0);
        tick();
    endtask

    task automatic test_degenerate();
        run_scan("single_beat", 16'hABCD, 8'd0, 8'd0, 16'h0040, 1'b0, 0, 1, -1, 1'b0);
        tick();
        run_scan("single_col", 16'h0F00, 8'd0, 8'd3, 16'h0100, 1'b0, 2, 1, -1, 1'b1);
        tick();
        run_scan("single_row", 16'hFFFC, 8'd5, 8'd0, 16'h0100, 1'b0, 2, 1, -1, 1'b1);
        tick();
        run_scan("single_repeat", 16'h0042, 8'd0, 8'd0, 16'h0000, 1'b1, 0, 3, 3, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        // Second start lands in the done cycle of the first frame.
        run_scan("b2b_first", 16'h2000, 8'd2, 8'd1, 16'h0003, 1'b0, 0, 1, -1, 1'b0);
        run_scan("b2b_second", 16'h3000, 8'd1, 8'd2, 16'h0020, 1'b0, 2, 1, -1, 1'b0);
        run_scan("b2b_third", 16'h0000, 8'd0, 8'd0, 16'h0000, 1'b0, 0, 1, -1, 1'b0);
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            run_scan("random", 16'($urandom), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 4)),
                     16'($urandom), 1'b0, 2, 1, -1, 1'b1);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_repeat_stop();
        test_degenerate();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_address_generator.md
# raster_address_generator

Parametrised 2D address generator for frame and window memories. It walks a rectangular region of `cols+1` by `rows+1` elements, starting at a runtime base address and advancing by a runtime row pitch. Each address is presented with a valid strobe (`nd`) under a ready/valid handshake, with optional continuous frame repeat. It sits between the control FSM and the line/frame buffer read or write ports, and replaces fixed-range free-running address counters.

## Interface
Parameters:
- ADDR_W, 16, address width; all address arithmetic is modulo 2^ADDR_W
- COL_W, 8, column counter width
- ROW_W, 8, row counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a scan; sampled only in IDLE
- stop  in  1  abort the current scan; sampled only when busy
- repeat  in  1  latched at start; 1 = restart at base after the last element
- base  in  ADDR_W  address of element (0,0); latched at start
- cols  in  COL_W  columns minus one; latched at start
- rows  in  ROW_W  rows minus one; latched at start
- stride  in  ADDR_W  row pitch (address delta between row starts); latched at start
- ready  in  1  downstream accepts the current address
- address  out  ADDR_W  current element address
- nd  out  1  address valid (new data)
- col  out  COL_W  current column index
- row  out  ROW_W  current row index
- last_col  out  1  high while nd=1 and col==cols
- last  out  1  high while nd=1 on element (cols,rows)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last element of a frame is accepted

## Operation
- States:
  - IDLE: busy=0, nd=0.
  - RUN: busy=1, nd=1.
- IDLE→RUN on start=1. This latches base, cols, rows, stride and repeat, and loads address=base, col=0, row=0, row_base=base.
- A transfer occurs on a cycle with nd=1 and ready=1. Without a transfer, address, col, row, last_col and last all hold (stall).
- On a transfer that is not the last element:
  - If col<cols: col+1 and address+1.
  - If col==cols: col=0, row+1, row_base=row_base+stride, address=row_base+stride.
- On a transfer of the last element (col==cols, row==rows):
  - done=1 on the next cycle.
  - If repeat=0: go to IDLE (nd=0).
  - If repeat=1: stay in RUN with address=base, col=0, row=0. nd stays 1 with no gap.
- stop=1 in RUN → IDLE next cycle, nd=0, no done. stop overrides a transfer in the same cycle.
- start while busy is ignored. Input changes while busy have no effect until the next start.
- start is accepted in the same cycle done is high after a non-repeat frame, so back-to-back frames are possible.
- cols=0 and/or rows=0 are legal: single column, single row, or a single element (last=1 on the first beat).
- Address overflow wraps modulo 2^ADDR_W; there is no error flag.
- stride is independent of cols, so windows narrower than the pitch and overlapping rows (stride<cols+1) are legal.

## Timing
- Reset: every output and internal register goes to 0 on the next clk edge, regardless of state. Reset mid-scan discards the scan.
- start at edge t → at t+1: busy=1, nd=1, address=base. Latency is 1 cycle.
- Throughput is 1 address per cycle while ready=1. A frame takes (cols+1)*(rows+1) transfer cycles plus stall cycles.
- done is registered. It is high exactly one cycle, the cycle after the last transfer; busy=0 in that cycle when repeat=0.
- last_col and last are combinational from registered state and qualified by nd.
- No combinational path from ready or start to any output.

## Test plan
- Reset/idle: assert reset mid-scan (row 1, col 2) → next cycle all outputs 0; start 1 cycle after reset release is accepted.
- Basic raster, ready=1: base=0x0100, cols=3, rows=2, stride=0x0010 → addresses 0x100–0x103, 0x110–0x113, 0x120–0x123 on consecutive cycles; last_col on each row end; last on 0x123; done 1 cycle later; busy=0.
- Back-pressure: same frame with ready toggled 1,0,0,1,… → each address held stable while ready=0; sequence and count (12) unchanged; done only after the 12th transfer.
- Repeat and stop: repeat=1, cols=1, rows=1, base=0xFFFE, stride=2 → FFFE, FFFF, 0000, 0001, FFFE, … (wrap); done pulses every 4 transfers with nd continuous; stop → nd=0 next cycle, no done.
- Degenerate/edge: cols=0, rows=0 → single beat with last=1, last_col=1; start asserted during RUN ignored; start asserted in the done cycle starts a new frame at the next edge.
